// File: rtl/spi_reg_controller.sv
// spi_reg_controller: frames SPI byte traffic on chip-select, decodes a read/write
// command byte and sequences auto-incrementing accesses to an 8-entry register bank.
`default_nettype none

module spi_reg_controller #(
  parameter logic [7:0] ID_BYTE     = 8'h5A,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        ssel,
  input  logic        byte_received,
  input  logic [7:0]  received_data,
  input  logic        data_needed,
  output logic [7:0]  data_to_send,
  output logic [7:0]  led,
  output logic [39:0] cfg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  state_t          state_q;
  logic            ssel_meta_q;
  logic            ssel_s_q;
  logic            ssel_prev_q;
  logic [1:0]      sync_vld_q;
  logic [2:0]      ptr_q;
  logic [7:0]      frame_cnt_q;
  logic [5:0][7:0] regs_q;
  logic [7:0]      data_to_send_q;

  logic            ssel_fall;
  logic            ssel_rise;
  logic [2:0]      rd_addr_d;
  logic [7:0]      rd_data_d;

  // The edge detector only trusts ssel_s once real samples have flushed the
  // reset value; otherwise a chip-select held low across reset would look like
  // a fresh frame start and the rest of the interrupted frame would be decoded.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      ssel_meta_q <= 1'b1;
      ssel_s_q    <= 1'b1;
      sync_vld_q  <= 2'b00;
      ssel_prev_q <= 1'b0;
    end else begin
      ssel_meta_q <= ssel;
      ssel_s_q    <= ssel_meta_q;
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
      ssel_prev_q <= sync_vld_q[1] ? ssel_s_q : 1'b0;
    end
  end

  assign ssel_fall = ssel_prev_q & ~ssel_s_q;
  assign ssel_rise = ~ssel_prev_q & ssel_s_q;

  // In CMD a read can be decoded and served in the same cycle, so the address
  // comes straight from the incoming command byte.
  always_comb begin
    rd_addr_d = (state_q == ST_CMD) ? received_data[2:0] : ptr_q;
    case (rd_addr_d)
      3'd6:    rd_data_d = frame_cnt_q;
      3'd7:    rd_data_d = ID_BYTE;
      default: rd_data_d = regs_q[rd_addr_d];
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= 3'd0;
      frame_cnt_q    <= 8'h00;
      regs_q         <= '0;
      data_to_send_q <= 8'h00;
    end else if (ssel_rise) begin
      if (state_q == ST_WR || state_q == ST_RD) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ssel_fall) begin
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (byte_received) begin
            ptr_q   <= received_data[2:0];
            state_q <= received_data[7] ? ST_WR : ST_RD;
          end
          if (data_needed) begin
            if (byte_received && !received_data[7]) begin
              data_to_send_q <= rd_data_d;
              ptr_q          <= received_data[2:0] + 3'd1;
            end else begin
              data_to_send_q <= STATUS_BYTE;
            end
          end
        end
        ST_WR: begin
          if (byte_received) begin
            if (ptr_q < 3'd6) begin
              regs_q[ptr_q] <= received_data;
            end
            ptr_q <= ptr_q + 3'd1;
          end
          if (data_needed) begin
            data_to_send_q <= STATUS_BYTE;
          end
        end
        ST_RD: begin
          if (data_needed) begin
            data_to_send_q <= rd_data_d;
            ptr_q          <= ptr_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_to_send = data_to_send_q;
  assign led          = regs_q[0];
  assign cfg          = {regs_q[5], regs_q[4], regs_q[3], regs_q[2], regs_q[1]};

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: directed byte-level stimulus for spi_reg_controller.
`default_nettype none

module tb_spi_reg_controller;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b1;
  logic        ssel = 1'b1;
  logic        byte_received = 1'b0;
  logic [7:0]  received_data = 8'h00;
  logic        data_needed = 1'b0;
  logic [7:0]  data_to_send;
  logic [7:0]  led;
  logic [39:0] cfg;

  int n_cmp = 0;
  int n_err = 0;

  spi_reg_controller #(
    .ID_BYTE     (8'h5A),
    .STATUS_BYTE (8'hA5)
  ) dut (
    .clk_25mhz     (clk_25mhz),
    .reset         (reset),
    .ssel          (ssel),
    .byte_received (byte_received),
    .received_data (received_data),
    .data_needed   (data_needed),
    .data_to_send  (data_to_send),
    .led           (led),
    .cfg           (cfg)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic br, input logic [7:0] b, input logic dn);
    @(negedge clk_25mhz);
    byte_received = br;
    received_data = b;
    data_needed   = dn;
    @(negedge clk_25mhz);
    byte_received = 1'b0;
    data_needed   = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk_25mhz);
    ssel = 1'b0;
    repeat (4) @(negedge clk_25mhz);
  endtask

  task automatic frame_end();
    @(negedge clk_25mhz);
    ssel = 1'b1;
    repeat (4) @(negedge clk_25mhz);
  endtask

  initial begin
    repeat (3) @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    chk("reset_dts", {32'h0, data_to_send}, 40'h0);
    chk("reset_led", {32'h0, led}, 40'h0);
    chk("reset_cfg", cfg, 40'h0);
    chk("reset_ptr", {37'h0, dut.ptr_q}, 40'h0);
    chk("reset_cnt", {32'h0, dut.frame_cnt_q}, 40'h0);

    // write burst {80,3C,11}
    frame_start();
    pulse(1'b0, 8'h00, 1'b1);
    chk("wr_status_b1", {32'h0, data_to_send}, 40'hA5);
    pulse(1'b1, 8'h80, 1'b0);
    pulse(1'b0, 8'h00, 1'b1);
    pulse(1'b1, 8'h3C, 1'b0);
    pulse(1'b0, 8'h00, 1'b1);
    chk("wr_status_b3", {32'h0, data_to_send}, 40'hA5);
    pulse(1'b1, 8'h11, 1'b0);
    frame_end();
    chk("wr_led", {32'h0, led}, 40'h3C);
    chk("wr_cfg", cfg, 40'h0000000011);
    chk("wr_cnt", {32'h0, dut.frame_cnt_q}, 40'd1);

    // preload r5 = 77
    frame_start();
    pulse(1'b1, 8'h85, 1'b0);
    pulse(1'b1, 8'h77, 1'b0);
    frame_end();
    chk("pre_cfg_r5", {32'h0, cfg[39:32]}, 40'h77);

    // read from 5 with wrap
    frame_start();
    pulse(1'b0, 8'h00, 1'b1);
    chk("rd_status", {32'h0, data_to_send}, 40'hA5);
    pulse(1'b1, 8'h05, 1'b0);
    pulse(1'b0, 8'h00, 1'b1);
    chk("rd_r5", {32'h0, data_to_send}, 40'h77);
    pulse(1'b1, 8'hEE, 1'b0);
    pulse(1'b0, 8'h00, 1'b1);
    chk("rd_r6", {32'h0, data_to_send}, 40'd2);
    pulse(1'b1, 8'hEE, 1'b0);
    pulse(1'b0, 8'h00, 1'b1);
    chk("rd_r7", {32'h0, data_to_send}, 40'h5A);
    chk("rd_ptr_wrap", {37'h0, dut.ptr_q}, 40'h0);
    pulse(1'b1, 8'hEE, 1'b0);
    repeat (3) @(negedge clk_25mhz);
    chk("rd_hold", {32'h0, data_to_send}, 40'h5A);
    frame_end();
    chk("rd_no_write", cfg, 40'h7700000011);
    chk("rd_cnt", {32'h0, dut.frame_cnt_q}, 40'd3);

    // read-only protection {86,FF,FF,42}
    frame_start();
    pulse(1'b1, 8'h86, 1'b0);
    pulse(1'b1, 8'hFF, 1'b0);
    pulse(1'b1, 8'hFF, 1'b0);
    pulse(1'b1, 8'h42, 1'b0);
    frame_end();
    chk("ro_led", {32'h0, led}, 40'h42);
    chk("ro_cnt", {32'h0, dut.frame_cnt_q}, 40'd4);
    frame_start();
    pulse(1'b0, 8'h00, 1'b1);
    pulse(1'b1, 8'h07, 1'b0);
    pulse(1'b0, 8'h00, 1'b1);
    chk("ro_id", {32'h0, data_to_send}, 40'h5A);
    frame_end();
    chk("ro_cnt2", {32'h0, dut.frame_cnt_q}, 40'd5);

    // aborted frame: no command byte completes
    @(negedge clk_25mhz);
    ssel = 1'b0;
    repeat (6) @(negedge clk_25mhz);
    frame_end();
    chk("abort_cnt", {32'h0, dut.frame_cnt_q}, 40'd5);
    chk("abort_led", {32'h0, led}, 40'h42);
    pulse(1'b1, 8'h80, 1'b1);
    chk("abort_idle_dts", {32'h0, data_to_send}, 40'h5A);
    chk("abort_idle_cfg", cfg, 40'h7700000011);

    // reset mid-frame after command 81
    frame_start();
    pulse(1'b1, 8'h81, 1'b0);
    @(negedge clk_25mhz);
    reset = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (5) @(negedge clk_25mhz);
    pulse(1'b1, 8'h99, 1'b1);
    pulse(1'b1, 8'h99, 1'b0);
    chk("rst_dts", {32'h0, data_to_send}, 40'h0);
    chk("rst_led", {32'h0, led}, 40'h0);
    chk("rst_cfg", cfg, 40'h0);
    frame_end();
    chk("rst_cnt", {32'h0, dut.frame_cnt_q}, 40'd0);
    frame_start();
    pulse(1'b1, 8'h81, 1'b0);
    pulse(1'b1, 8'h99, 1'b0);
    frame_end();
    chk("rst_wr_r1", cfg, 40'h0000000099);
    chk("rst_wr_cnt", {32'h0, dut.frame_cnt_q}, 40'd1);

    // simultaneous command and data_needed
    frame_start();
    pulse(1'b1, 8'h82, 1'b0);
    pulse(1'b1, 8'h5C, 1'b0);
    frame_end();
    frame_start();
    pulse(1'b1, 8'h02, 1'b1);
    chk("sim_dts", {32'h0, data_to_send}, 40'h5C);
    chk("sim_ptr", {37'h0, dut.ptr_q}, 40'd3);
    pulse(1'b0, 8'h00, 1'b1);
    chk("sim_next", {32'h0, data_to_send}, 40'h00);
    frame_end();
    chk("sim_cfg", cfg, 40'h0000005C99);
    chk("sim_cnt", {32'h0, dut.frame_cnt_q}, 40'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_controller.md
# spi_reg_controller

Byte-level controller between the SPI slave's byte interface and a small on-chip register bank. It frames transactions on chip-select, decodes the first byte of each frame as a read/write command, and then sequences the remaining bytes of the frame. Write data goes into the addressed registers with address auto-increment. Read data is loaded into the slave's transmit byte on each request. Register 0 drives the board LEDs, and registers 1–5 drive a configuration bus for downstream logic.

## Interface
- `ID_BYTE`, default 8'h5A: constant value returned when register 7 is read.
- `STATUS_BYTE`, default 8'hA5: byte shifted out on MISO during every command byte.
- `clk_25mhz`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ssel`  in  1  raw SPI chip-select, active-low, asynchronous to `clk_25mhz`.
- `byte_received`  in  1  single-cycle pulse from the SPI slave; `received_data` is valid in the same cycle.
- `received_data`  in  8  byte just received from the master.
- `data_needed`  in  1  single-cycle pulse from the SPI slave requesting the next transmit byte.
- `data_to_send`  out  8  registered transmit byte presented to the SPI slave.
- `led`  out  8  contents of register 0.
- `cfg`  out  40  contents of registers 5..1 as {r5,r4,r3,r2,r1}.

## Operation
- `ssel` passes through a 2-flop synchronizer; the result is `ssel_s`. A frame starts on a falling edge of `ssel_s` and ends on a rising edge.
- Command byte format:
  - bit7 = 1 means write, 0 means read.
  - bits[2:0] = start address.
  - bits[6:3] are ignored.
- Register map:
  - r0–r5 are read/write, 8 bits each, reset value 0.
  - r6 is read-only: completed-frame counter, wraps 255→0.
  - r7 is read-only: `ID_BYTE`.
  - Writes to r6/r7 are discarded, but the address still advances.
- The address pointer `ptr` is 3 bits and increments after each data byte. It wraps 7→0.
- States:
  - IDLE: frame inactive; `byte_received` and `data_needed` are ignored. On `ssel_s` fall → CMD.
  - CMD: on `byte_received`, latch `ptr` = bits[2:0], then go to WR if bit7 = 1, otherwise RD.
  - WR: on `byte_received`, write `received_data` to r[`ptr`] and increment `ptr`.
  - RD: on `data_needed`, load `data_to_send` with r[`ptr`] and increment `ptr`. `byte_received` is ignored, so master bytes are don't-care.
  - Any state: on `ssel_s` rise → IDLE. r6 increments on this rise only if the frame left CMD.
- `data_needed` while in CMD or WR: load `STATUS_BYTE`.
- Slave contract: `byte_received` for byte N precedes or coincides with `data_needed` for byte N+1. A read frame is therefore: command byte, then r[a], r[a+1], … on MISO from byte 2 onward.
- If `byte_received` (command) and `data_needed` occur in the same cycle in CMD, the command is decoded first. The load uses the new address and read/write decision, and `ptr` is incremented for a read.
- A frame whose `ssel_s` rises before a command byte completes has no effect, and r6 is unchanged.
- Reset mid-frame: all state returns to reset values and the FSM goes to IDLE. It re-enters CMD only on the next `ssel_s` fall, so the remainder of the interrupted frame is ignored.

## Timing
- Reset values:
  - `data_to_send` = 8'h00
  - `led` = 8'h00
  - `cfg` = 40'h0
  - r6 = 0, `ptr` = 0
  - state = IDLE
  - synchronizer flops = 1 (deasserted).
- `ssel` to state change: 3 rising edges (2 synchronizer stages plus one edge-detect/FSM edge).
- Write latency: register, `led` and `cfg` update on the first edge after the `byte_received` cycle.
- Read latency: `data_to_send` is valid on the first edge after the `data_needed` cycle and holds until the next load.
- If a write to r[k] and a read of r[k] occur in the same cycle, the read returns the old value (cannot occur within one frame; stated for completeness).
- r6 increments on the same edge as the transition to IDLE.

## Test plan
- Write burst: frame {8'h80, 8'h3C, 8'h11} → `led` = 8'h3C, `cfg[7:0]` = 8'h11, r6 = 1; MISO byte 1 = 8'hA5.
- Read with wrap: preload r5 = 8'h77; frame {8'h05, x, x, x} → `data_to_send` sequence A5, 77, r6 value, 5A (r5, r6, r7), then `ptr` wraps to 0.
- Read-only protection: frame {8'h86, 8'hFF, 8'hFF, 8'h42} → r6/r7 unchanged, r0 = 8'h42.
- Aborted frame: `ssel` low, 3 bits clocked, `ssel` high → no register change, r6 unchanged, state back in IDLE.
- Reset mid-frame: assert `reset` after command 8'h81 while `ssel` stays low, then send 8'h99 → all outputs 0, 8'h99 ignored; next full frame {8'h81, 8'h99} writes r1 = 8'h99.
- Simultaneous pulse: `byte_received` with 8'h02 and `data_needed` in the same cycle → `data_to_send` = r2 on the next edge, `ptr` = 3.
